// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg -- shared types and constants for the DMA command scheduler.
//   state_t   : scheduler FSM state encoding
//   SEL_*     : DMA register indices written during programming
//   prog_sel  : maps the programming step (0..4) to the register index, so
//               the start register is always written last
// ---------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_CHECK,
    ST_PROG,
    ST_START_WAIT,
    ST_RUN,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [2:0] SEL_COLS  = 3'd0;
  localparam logic [2:0] SEL_ROWS  = 3'd1;
  localparam logic [2:0] SEL_SET   = 3'd2;
  localparam logic [2:0] SEL_START = 3'd3;
  localparam logic [2:0] SEL_ADDR  = 3'd4;

  localparam int PROG_WRITES = 5;

  function automatic logic [2:0] prog_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    return SEL_COLS;
      3'd1:    return SEL_ROWS;
      3'd2:    return SEL_SET;
      3'd3:    return SEL_ADDR;
      default: return SEL_START;
    endcase
  endfunction

endpackage

// File: rtl/dma_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// dma_cmd_sched_if -- bundle of the scheduler's requester, DMA register and
// completion signals.
//   master : scheduler view (drives req_ready, dma_*, done_*, fault)
//   slave  : environment view (requesters + DMA engine)
// Per-requester descriptor fields are packed, requester i at
// [i*DATAWIDTH +: DATAWIDTH] (req_set at [2i+1:2i]).
// ---------------------------------------------------------------------------
interface dma_cmd_sched_if #(
  parameter int DATAWIDTH = 8
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [2*DATAWIDTH-1:0] req_cols;
  logic [2*DATAWIDTH-1:0] req_rows;
  logic [3:0]             req_set;
  logic [2*DATAWIDTH-1:0] req_addr;
  logic                   dma_write;
  logic [2:0]             dma_select;
  logic [DATAWIDTH-1:0]   dma_data;
  logic                   dma_busy;
  logic                   done_valid;
  logic                   done_id;
  logic                   done_err;
  logic                   fault;

  modport master (
    input  req_valid, req_cols, req_rows, req_set, req_addr, dma_busy,
    output req_ready, dma_write, dma_select, dma_data,
           done_valid, done_id, done_err, fault
  );

  modport slave (
    output req_valid, req_cols, req_rows, req_set, req_addr, dma_busy,
    input  req_ready, dma_write, dma_select, dma_data,
           done_valid, done_id, done_err, fault
  );
endinterface

// File: rtl/dma_cmd_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 -- two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : per-requester request
//   advance  : the current grant is taken; remember it as last winner
//   grant    : one-hot winner (combinational), zero when nobody is valid
// The last-winner pointer resets to 1 so requester 0 wins the first tie.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end
endmodule

// File: rtl/dma_cmd_sched.sv
// ---------------------------------------------------------------------------
// dma_cmd_sched -- picks one of two requesters round-robin, validates its
// 2-D descriptor, programs the DMA register file (cols, rows, set, addr,
// then start), supervises the run with a watchdog and reports completion.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dma_cmd_sched_if.master (requesters, DMA registers, done/fault)
// Params: DATAWIDTH register width, TIMEOUT watchdog limit in cycles.
// All outputs are registered; a watchdog expiry parks the block in FAULT
// until reset.
// ---------------------------------------------------------------------------
module dma_cmd_sched
  import dma_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst,
  dma_cmd_sched_if.master  bus
);
  localparam int DW  = DATAWIDTH;
  localparam int PW  = 2 * DW;
  localparam int WDW = $clog2(TIMEOUT + 1);
  // One past the highest addressable location.
  localparam logic [PW:0] ADDR_SPAN = (PW + 1)'(1) << DW;

  state_t         state_q;
  logic [1:0]     req_ready_q;
  logic           dma_write_q;
  logic [2:0]     dma_select_q;
  logic [DW-1:0]  dma_data_q;
  logic           done_valid_q, done_id_q, done_err_q, fault_q;
  logic [DW-1:0]  cols_q, rows_q, addr_q;
  logic [1:0]     set_q;
  logic           gnt_id_q;
  logic [2:0]     prog_idx_q;
  logic [WDW-1:0] wd_q, wd_d;
  logic           busy_q;

  // Unpack the per-requester descriptor fields.
  logic [DW-1:0] cols_arr [0:1];
  logic [DW-1:0] rows_arr [0:1];
  logic [DW-1:0] addr_arr [0:1];
  logic [1:0]    set_arr  [0:1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign cols_arr[gi] = bus.req_cols[gi*DW +: DW];
      assign rows_arr[gi] = bus.req_rows[gi*DW +: DW];
      assign addr_arr[gi] = bus.req_addr[gi*DW +: DW];
      assign set_arr[gi]  = bus.req_set[2*gi +: 2];
    end
  endgenerate

  // The winner is chosen on the IDLE->ARB edge so req_ready can be a
  // registered pulse that covers exactly the ARB cycle.
  logic [1:0] grant;
  logic       arb_go;
  assign arb_go = (state_q == ST_IDLE) && (bus.req_valid != 2'b00) &&
                  !bus.dma_busy && !fault_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .advance (arb_go),
    .grant   (grant)
  );

  // Descriptor validation: the transfer must be non-empty and its last
  // element must still fall inside the DATAWIDTH address space.
  logic [PW-1:0] area;
  logic [PW:0]   end_excl;
  logic          reject;
  assign area     = {{DW{1'b0}}, cols_q} * {{DW{1'b0}}, rows_q};
  assign end_excl = {1'b0, {DW{1'b0}}, addr_q} + {1'b0, area};
  assign reject   = (cols_q == '0) || (rows_q == '0) || (end_excl > ADDR_SPAN);

  // Register write to present on the next cycle of PROG.
  logic [2:0]    nxt_idx, nxt_sel;
  logic [DW-1:0] nxt_data;
  always_comb begin
    nxt_idx  = (state_q == ST_PROG) ? prog_idx_q + 3'd1 : 3'd0;
    nxt_sel  = prog_sel(nxt_idx);
    nxt_data = '0;
    case (nxt_sel)
      SEL_COLS:  nxt_data = cols_q;
      SEL_ROWS:  nxt_data = rows_q;
      SEL_SET:   nxt_data = DW'(set_q);
      SEL_ADDR:  nxt_data = addr_q;
      SEL_START: nxt_data = DW'(1);
      default:   nxt_data = '0;
    endcase
  end

  logic timeout_hit;
  assign wd_d        = wd_q + 1'b1;
  assign timeout_hit = (wd_d == WDW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= '0;
      dma_write_q  <= 1'b0;
      dma_select_q <= '0;
      dma_data_q   <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      done_err_q   <= 1'b0;
      fault_q      <= 1'b0;
      cols_q       <= '0;
      rows_q       <= '0;
      addr_q       <= '0;
      set_q        <= '0;
      gnt_id_q     <= 1'b0;
      prog_idx_q   <= '0;
      wd_q         <= '0;
      busy_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      req_ready_q  <= '0;
      dma_write_q  <= 1'b0;
      dma_select_q <= '0;
      dma_data_q   <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      done_err_q   <= 1'b0;
      busy_q       <= bus.dma_busy;
      case (state_q)
        ST_IDLE: begin
          if (arb_go) begin
            req_ready_q <= grant;
            gnt_id_q    <= grant[1];
            state_q     <= ST_ARB;
          end
        end
        ST_ARB: begin
          cols_q  <= cols_arr[gnt_id_q];
          rows_q  <= rows_arr[gnt_id_q];
          addr_q  <= addr_arr[gnt_id_q];
          set_q   <= set_arr[gnt_id_q];
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (reject) begin
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_id_q    <= gnt_id_q;
            state_q      <= ST_DONE;
          end else begin
            prog_idx_q   <= 3'd0;
            dma_write_q  <= 1'b1;
            dma_select_q <= nxt_sel;
            dma_data_q   <= nxt_data;
            state_q      <= ST_PROG;
          end
        end
        ST_PROG: begin
          if (prog_idx_q == 3'(PROG_WRITES - 1)) begin
            wd_q    <= '0;
            state_q <= ST_START_WAIT;
          end else begin
            prog_idx_q   <= nxt_idx;
            dma_write_q  <= 1'b1;
            dma_select_q <= nxt_sel;
            dma_data_q   <= nxt_data;
          end
        end
        ST_START_WAIT, ST_RUN: begin
          wd_q <= wd_d;
          if (timeout_hit) begin
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_id_q    <= gnt_id_q;
            fault_q      <= 1'b1;
            state_q      <= ST_FAULT;
          end else if (state_q == ST_START_WAIT) begin
            if (bus.dma_busy) state_q <= ST_RUN;
          end else if (busy_q && !bus.dma_busy) begin
            // Falling edge of busy is the only completion indication used.
            done_valid_q <= 1'b1;
            done_id_q    <= gnt_id_q;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.dma_write  = dma_write_q;
  assign bus.dma_select = dma_select_q;
  assign bus.dma_data   = dma_data_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_err   = done_err_q;
  assign bus.fault      = fault_q;
endmodule

// File: tb/tb_dma_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_dma_cmd_sched -- self-checking bench for dma_cmd_sched.
// A negedge monitor logs register writes, grants and completions; a small
// DMA model raises busy one cycle after the start write for busy_len cycles
// (busy_len=0: never). Expected results come from the descriptor rules
// evaluated with integer arithmetic and a round-robin winner model.
// ---------------------------------------------------------------------------
module tb_dma_cmd_sched;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_cmd_sched_if #(.DATAWIDTH(DW)) bus ();

  dma_cmd_sched #(.DATAWIDTH(DW), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int sel; int data; int cyc; } wr_t;
  typedef struct { int id; int err; int cyc; } done_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    busy_len = 0;
  int    busy_cnt = 0;
  bit    busy_pend = 1'b0;
  int    model_last = 1;
  wr_t   wr_log[$];
  int    grant_log[$];
  done_t done_log[$];
  wr_t   mon_w;
  done_t mon_d;

  always @(posedge clk) cyc++;

  // Monitor + DMA model, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.dma_busy = 1'b0;
      busy_cnt     = 0;
      busy_pend    = 1'b0;
    end else begin
      if (bus.dma_write) begin
        mon_w.sel  = int'(bus.dma_select);
        mon_w.data = int'(bus.dma_data);
        mon_w.cyc  = cyc;
        wr_log.push_back(mon_w);
      end
      if (bus.req_ready[0]) grant_log.push_back(0);
      if (bus.req_ready[1]) grant_log.push_back(1);
      if (bus.done_valid) begin
        mon_d.id  = int'(bus.done_id);
        mon_d.err = int'(bus.done_err);
        mon_d.cyc = cyc;
        done_log.push_back(mon_d);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.dma_busy = 1'b0;
      end else if (busy_pend) begin
        busy_pend = 1'b0;
        if (busy_len > 0) begin
          bus.dma_busy = 1'b1;
          busy_cnt     = busy_len;
        end
      end
      if (bus.dma_write && bus.dma_select == 3'd3) busy_pend = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    grant_log.delete();
    done_log.delete();
  endtask

  task automatic set_desc(input int id, input int cols, input int rows,
                          input int set, input int addr);
    bus.req_cols[id*DW +: DW] = DW'(cols);
    bus.req_rows[id*DW +: DW] = DW'(rows);
    bus.req_addr[id*DW +: DW] = DW'(addr);
    bus.req_set[2*id +: 2]    = 2'(set);
  endtask

  // All outputs must be zero; used both in reset and right after an async reset.
  task automatic check_outputs_zero(input string tag);
    vectors++;
    if (bus.req_ready !== 2'b00 || bus.dma_write !== 1'b0 || bus.dma_select !== 3'd0 ||
        bus.dma_data !== 8'd0 || bus.done_valid !== 1'b0 || bus.done_id !== 1'b0 ||
        bus.done_err !== 1'b0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b wr=%b sel=%0d data=%0d dv=%b id=%b err=%b fault=%b, all required 0",
               tag, bus.req_ready, bus.dma_write, bus.dma_select, bus.dma_data,
               bus.done_valid, bus.done_id, bus.done_err, bus.fault);
    end
  endtask

  // One complete job from a sole requester, checked against the rules.
  task automatic do_job(input int id, input int cols, input int rows,
                        input int set, input int addr, input int blen);
    int n;
    bit exp_ok;
    int exp_sel[5];
    int exp_data[5];
    clear_logs();
    busy_len = blen;
    set_desc(id, cols, rows, set, addr);
    bus.req_valid[id] = 1'b1;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    bus.req_valid[id] = 1'b0;
    // Descriptor is captured at grant; scribbling on it now must not matter.
    set_desc(id, $urandom, $urandom, $urandom, $urandom);
    n = 0;
    while (done_log.size() == 0 && n < 400) begin tick(); n++; end
    repeat (3) tick();

    model_last = id;
    exp_ok = (cols != 0) && (rows != 0) && (addr + cols * rows - 1 <= 255);
    exp_sel  = '{0, 1, 2, 4, 3};
    exp_data = '{cols, rows, set, addr, 1};

    vectors++;
    if (grant_log.size() != 1) begin
      miscompares++;
      $display("FAIL grant_count: got %0d req_ready pulses, required 1", grant_log.size());
    end else if (grant_log[0] != id) begin
      miscompares++;
      $display("FAIL grant_id: got %0d, required %0d", grant_log[0], id);
    end
    vectors++;
    if (done_log.size() != 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d done pulses, required 1", done_log.size());
    end else if (done_log[0].id != id || done_log[0].err != int'(!exp_ok)) begin
      miscompares++;
      $display("FAIL done: got id=%0d err=%0d, required id=%0d err=%0d",
               done_log[0].id, done_log[0].err, id, int'(!exp_ok));
    end
    vectors++;
    if (wr_log.size() != (exp_ok ? 5 : 0)) begin
      miscompares++;
      $display("FAIL write_count: got %0d dma writes, required %0d", wr_log.size(), exp_ok ? 5 : 0);
    end else if (exp_ok) begin
      for (int k = 0; k < 5; k++) begin
        vectors++;
        if (wr_log[k].sel != exp_sel[k] || wr_log[k].data != exp_data[k]) begin
          miscompares++;
          $display("FAIL write%0d: got (%0d,0x%0h), required (%0d,0x%0h)",
                   k, wr_log[k].sel, wr_log[k].data, exp_sel[k], exp_data[k]);
        end
      end
    end
    $display("job req=%0d cols=%0d rows=%0d set=%0d addr=0x%0h busy=%0d -> writes=%0d done=%0d expect_err=%0d",
             id, cols, rows, set, addr, blen, wr_log.size(), done_log.size(), int'(!exp_ok));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    model_last = 1;
    repeat (2) tick();
    check_outputs_zero("idle_outputs");
    $display("reset checked");
  endtask

  task automatic test_basic();
    do_job(0, 2, 3, 2, 'h10, 8);
  endtask

  task automatic test_reject();
    do_job(1, 0, 5, 1, 'h00, 4);
    do_job(0, 4, 8, 0, 'hF0, 4);
    // Boundary: last element exactly at 0xFF is still legal.
    do_job(1, 4, 4, 3, 'hF0, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      do_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 255)), int'($urandom_range(1, 12)));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int winner;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_last = 1;
    clear_logs();
    busy_len = 3;
    set_desc(0, 1, 2, 0, 'h00);
    set_desc(1, 3, 1, 3, 'h05);
    bus.req_valid = 2'b11;
    n = 0;
    while (done_log.size() < 4 && n < 300) begin tick(); n++; end
    bus.req_valid = 2'b00;
    repeat (3) tick();
    vectors++;
    if (grant_log.size() != 4 || done_log.size() != 4 || wr_log.size() != 20) begin
      miscompares++;
      $display("FAIL b2b_counts: grants=%0d dones=%0d writes=%0d, required 4/4/20",
               grant_log.size(), done_log.size(), wr_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        winner = (model_last == 1) ? 0 : 1;
        model_last = winner;
        vectors++;
        if (grant_log[k] != winner || done_log[k].id != winner || done_log[k].err != 0) begin
          miscompares++;
          $display("FAIL b2b_job%0d: grant=%0d done_id=%0d err=%0d, required grant=%0d id=%0d err=0",
                   k, grant_log[k], done_log[k].id, done_log[k].err, winner, winner);
        end
        $display("b2b job %0d granted req=%0d", k, grant_log[k]);
      end
    end
  endtask

  task automatic test_reset_mid_prog();
    int n;
    clear_logs();
    busy_len = 5;
    set_desc(1, 5, 5, 1, 'h20);
    bus.req_valid[1] = 1'b1;
    n = 0;
    while (wr_log.size() < 2 && n < 40) begin
      tick();
      n++;
      if (grant_log.size() > 0) bus.req_valid[1] = 1'b0;
    end
    bus.req_valid = 2'b00;
    vectors++;
    if (wr_log.size() != 2) begin
      miscompares++;
      $display("FAIL midprog_reach: got %0d writes before reset point, required 2", wr_log.size());
    end
    // Third write is on the bus now; reset must clear outputs without a clock.
    rst = 1'b1;
    #1;
    check_outputs_zero("midprog_async_reset");
    repeat (2) tick();
    rst = 1'b0;
    model_last = 1;
    tick();
    $display("reset during third write applied");
    do_job(0, 2, 2, 1, 'h40, 4);
  endtask

  task automatic test_fault();
    int n;
    clear_logs();
    busy_len = 0;
    set_desc(0, 1, 1, 0, 'h00);
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (grant_log.size() == 0 && n < 20) begin tick(); n++; end
    bus.req_valid = 2'b00;
    n = 0;
    while (done_log.size() == 0 && n < 400) begin tick(); n++; end
    tick();
    vectors++;
    if (done_log.size() != 1 || wr_log.size() != 5) begin
      miscompares++;
      $display("FAIL fault_events: dones=%0d writes=%0d, required 1/5", done_log.size(), wr_log.size());
    end else begin
      vectors++;
      if (done_log[0].err != 1 || done_log[0].id != 0) begin
        miscompares++;
        $display("FAIL fault_done: got id=%0d err=%0d, required id=0 err=1",
                 done_log[0].id, done_log[0].err);
      end
      // 255 watchdog cycles after the start write, plus the pulse cycle.
      vectors++;
      if (done_log[0].cyc - wr_log[4].cyc != 256) begin
        miscompares++;
        $display("FAIL fault_latency: got %0d cycles after start write, required 256",
                 done_log[0].cyc - wr_log[4].cyc);
      end
    end
    vectors++;
    if (bus.fault !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_flag: got %b, required 1", bus.fault);
    end
    bus.req_valid = 2'b11;
    repeat (30) tick();
    bus.req_valid = 2'b00;
    vectors++;
    if (grant_log.size() != 1 || done_log.size() != 1 || bus.fault !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_lockout: grants=%0d dones=%0d fault=%b, required 1/1/1",
               grant_log.size(), done_log.size(), bus.fault);
    end
    $display("fault scenario: dones=%0d fault=%b", done_log.size(), bus.fault);
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_cols  = '0;
    bus.req_rows  = '0;
    bus.req_addr  = '0;
    bus.req_set   = '0;
    test_reset();
    test_basic();
    test_reject();
    test_random();
    test_back_to_back();
    test_reset_mid_prog();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dma_cmd_sched.md
DMA_CMD_SCHED -- requirements
Module: dma_cmd_sched

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, the DMA register/data width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the watchdog limit in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester descriptor valid.
REQ-006 SHALL have port req_ready  output  2  one-cycle grant/accept pulse per requester.
REQ-007 SHALL have port req_cols  input  2*DATAWIDTH  column count; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
REQ-008 SHALL have port req_rows  input  2*DATAWIDTH  row count, packed as req_cols.
REQ-009 SHALL have port req_set  input  4  target set (0=A,1=B,2=X pop,3=W); requester i uses bits [2i+1:2i].
REQ-010 SHALL have port req_addr  input  2*DATAWIDTH  source address, packed as req_cols.
REQ-011 SHALL have port dma_write  output  1  DMA register write strobe.
REQ-012 SHALL have port dma_select  output  3  DMA register index.
REQ-013 SHALL have port dma_data  output  DATAWIDTH  DMA register write data.
REQ-014 SHALL have port dma_busy  input  1  DMA busy.
REQ-015 SHALL have port done_valid  output  1  one-cycle completion pulse.
REQ-016 SHALL have port done_id  output  1  requester owning the completion.
REQ-017 SHALL have port done_err  output  1  completion is a reject or timeout.
REQ-018 SHALL have port fault  output  1  sticky watchdog fault.

Function
REQ-019 SHALL implement the FSM IDLE -> ARB -> CHECK -> PROG -> START_WAIT -> RUN -> DONE -> IDLE, with CHECK -> DONE on reject and START_WAIT/RUN -> FAULT on timeout.
REQ-020 SHALL leave IDLE only when any req_valid=1, dma_busy=0 and fault=0.
REQ-021 SHALL arbitrate round-robin in ARB: a sole valid requester wins; when both are valid, the one not granted last wins; last-grant pointer resets to 1, so requester 0 wins first.
REQ-022 SHALL pulse req_ready for the winner for exactly one ARB cycle and capture its cols/rows/set/addr on that edge; descriptors are not re-sampled afterwards.
REQ-023 SHALL in CHECK compute cols*rows at 2*DATAWIDTH bits and reject when cols=0, rows=0, or addr+cols*rows-1 > 2^DATAWIDTH-1.
REQ-024 SHALL on reject go to DONE with done_err=1 and perform no DMA write.
REQ-025 SHALL in PROG issue five consecutive single-cycle writes with dma_write=1: select 0=cols, 1=rows, 2=zero-extended set, 4=addr, 3=1 (start); start is always last.
REQ-026 SHALL hold dma_write=0, dma_select=0 and dma_data=0 outside PROG.
REQ-027 SHALL in START_WAIT wait for dma_busy=1, then enter RUN.
REQ-028 SHALL in RUN detect completion only as dma_busy 1->0 and then enter DONE; DMA finished flags are sticky and are not used.
REQ-029 SHALL clear a watchdog counter on entry to START_WAIT, increment it each START_WAIT/RUN cycle, and enter FAULT when it reaches TIMEOUT.
REQ-030 SHALL in DONE assert done_valid for one cycle with done_id equal to the granted requester.
REQ-031 SHALL in FAULT pulse done_valid=1 with done_err=1 once, set fault=1, and stay in FAULT until reset; no further grants.
REQ-032 SHALL ignore a requester dropping req_valid before its grant; no queueing or preemption.

Reset
REQ-033 SHALL on rst return asynchronously to IDLE, including mid-PROG or mid-RUN; no partial write completes.
REQ-034 SHALL drive every output to 0 while in reset.
REQ-035 SHALL reset the captured descriptor, watchdog counter and PROG index to 0.

Structure
REQ-036 SHALL take the state enum and DMA register index constants (SEL_COLS=0, SEL_ROWS=1, SEL_SET=2, SEL_START=3, SEL_ADDR=4) from the shared package dma_pkg.
REQ-037 SHALL place the round-robin arbiter in sub-module rr_arb2 (valid[1:0], advance -> grant[1:0]); the rest stays flat.

Verification
REQ-038 SHALL cover: req0 cols=2 rows=3 set=2 addr=0x10; DMA model busy for 8 cycles -> writes (0,2)(1,3)(2,2)(4,0x10)(3,1), then done_valid id=0 err=0.
REQ-039 SHALL cover: both requesters valid continuously for 4 jobs -> grant order 0,1,0,1.
REQ-040 SHALL cover: cols=0, and separately addr=0xF0 cols=4 rows=8 -> done_err=1 with zero dma_write pulses.
REQ-041 SHALL cover: busy never rises after start -> FAULT after 255 cycles, fault=1, done_err pulse, later req_valid gets no req_ready.
REQ-042 SHALL cover: rst asserted during the third PROG write -> outputs 0 immediately; a fresh request then programs all five registers from select 0.
